// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared types and helpers for the spectrum bar renderer.
//   state_e       - renderer FSM states
//   line_cmd_t    - one line_drawer command (endpoints and colour)
//   clamp_height  - limits a magnitude to the drawable height
package spectrum_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StBar,
    StPeak,
    StNext,
    StDone
  } state_e;

  // Command fields are sized for the 640x480 display the renderer targets.
  localparam int unsigned LINE_X_W = 10;
  localparam int unsigned LINE_Y_W = 9;

  typedef struct packed {
    logic [LINE_X_W-1:0] x0;
    logic [LINE_X_W-1:0] x1;
    logic [LINE_Y_W-1:0] y0;
    logic [LINE_Y_W-1:0] y1;
    logic                color;
  } line_cmd_t;

  // Tallest bar is max_y-1 pixels so the top row stays on screen.
  function automatic int unsigned clamp_height(input int unsigned mag,
                                               input int unsigned max_y);
    return (mag >= max_y) ? max_y - 1 : mag;
  endfunction

endpackage

// File: rtl/peak_hold_mem.sv
// peak_hold_mem: per-bin peak-hold storage with a single read/update port.
//   clk, reset - clock and synchronous active-high reset (clears all peaks)
//   i_we       - write the updated peak back to i_addr this cycle
//   i_addr     - bin index
//   i_mag      - current magnitude of the bin
//   o_peak     - updated peak: max(i_mag, stored peak - DECAY saturating at 0)
module peak_hold_mem #(
  parameter int unsigned NUM_BINS = 512,
  parameter int unsigned MAG_W    = 9,
  parameter int unsigned DECAY    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_we,
  input  logic [$clog2(NUM_BINS)-1:0] i_addr,
  input  logic [MAG_W-1:0]            i_mag,
  output logic [MAG_W-1:0]            o_peak
);

  logic [MAG_W-1:0] r_mem [NUM_BINS];
  logic [MAG_W-1:0] w_old;
  logic [MAG_W-1:0] w_decayed;

  always_comb begin
    w_old     = r_mem[i_addr];
    w_decayed = (w_old > MAG_W'(DECAY)) ? w_old - MAG_W'(DECAY) : '0;
    o_peak    = (i_mag > w_decayed) ? i_mag : w_decayed;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= o_peak;
    end
  end

endmodule

// File: rtl/spectrum_bar_renderer.sv
// spectrum_bar_renderer: per-frame renderer from the magnitude RAM to line_drawer.
// Reads one magnitude per bin, issues one vertical bar per display column and an
// optional peak-hold marker per column, over a valid/ready command handshake.
//   clk, reset      - clock, synchronous active-high reset
//   i_start         - frame start pulse (ignored while busy)
//   i_peak_en       - draw peak markers this frame (sampled at start)
//   o_mag_addr      - magnitude RAM address; i_mag_data valid one cycle later
//   o_cmd_valid     - line command valid; i_cmd_ready accepts it
//   o_x0/x1/y0/y1   - line endpoints (x0 == x1), o_color pixel colour
//   o_busy          - high outside idle
//   o_frame_done    - one-cycle pulse after the final command is accepted
module spectrum_bar_renderer
  import spectrum_pkg::*;
#(
  parameter int unsigned NUM_BINS = 512,
  parameter int unsigned MAG_W    = 9,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned MAX_X    = 640,
  parameter int unsigned MAX_Y    = 480,
  parameter int unsigned BAR_W    = 1,
  parameter int unsigned DECAY    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic                        i_peak_en,
  output logic [$clog2(NUM_BINS)-1:0] o_mag_addr,
  input  logic [MAG_W-1:0]            i_mag_data,
  output logic                        o_cmd_valid,
  input  logic                        i_cmd_ready,
  output logic [X_W-1:0]              o_x0,
  output logic [X_W-1:0]              o_x1,
  output logic [Y_W-1:0]              o_y0,
  output logic [Y_W-1:0]              o_y1,
  output logic                        o_color,
  output logic                        o_busy,
  output logic                        o_frame_done
);

  localparam int unsigned BIN_W = $clog2(NUM_BINS);
  // Wide enough that bin*BAR_W+col never wraps before the range check.
  localparam int unsigned XW3   = X_W + 3;
  localparam int unsigned COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [Y_W-1:0] Y_BOTTOM = Y_W'(MAX_Y - 1);

  state_e           r_state;
  logic             r_peak_en;
  logic [BIN_W-1:0] r_bin;
  logic [COL_W-1:0] r_col;
  logic [XW3-1:0]   r_x;
  logic [Y_W-1:0]   r_bar_y;
  logic [Y_W-1:0]   r_peak_y;
  logic [BIN_W-1:0] r_mag_addr;
  logic             r_cmd_valid;
  line_cmd_t        r_cmd;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_fire;
  logic [XW3-1:0]   w_x_inc;
  logic             w_col_last;
  logic             w_bin_last;
  logic             w_last;
  logic [MAG_W-1:0] w_peak;
  logic [Y_W-1:0]   w_bar_y;
  logic [Y_W-1:0]   w_peak_y;

  peak_hold_mem #(
    .NUM_BINS (NUM_BINS),
    .MAG_W    (MAG_W),
    .DECAY    (DECAY)
  ) u_peak_hold_mem (
    .clk    (clk),
    .reset  (reset),
    .i_we   (r_state == StWait),
    .i_addr (r_bin),
    .i_mag  (i_mag_data),
    .o_peak (w_peak)
  );

  function automatic line_cmd_t make_cmd(input logic [XW3-1:0] x,
                                         input logic [Y_W-1:0] ya,
                                         input logic [Y_W-1:0] yb);
    line_cmd_t c;
    c.x0    = LINE_X_W'(x);
    c.x1    = LINE_X_W'(x);
    c.y0    = LINE_Y_W'(ya);
    c.y1    = LINE_Y_W'(yb);
    c.color = 1'b1;
    return c;
  endfunction

  always_comb begin
    w_fire   = r_cmd_valid & i_cmd_ready;
    // x steps by one per column across bins, since x = bin*BAR_W + col.
    w_x_inc  = r_x + XW3'(1);
    // A column is the bin's last if it is column BAR_W-1 or the next x is off screen.
    w_col_last = (r_col == COL_W'(BAR_W - 1)) || (w_x_inc >= XW3'(MAX_X));
    // On the last column, x+1 equals (bin+1)*BAR_W.
    w_bin_last = (r_bin == BIN_W'(NUM_BINS - 1)) || (w_x_inc >= XW3'(MAX_X));
    w_last   = w_col_last && w_bin_last;
    w_bar_y  = Y_BOTTOM - Y_W'(clamp_height(32'(i_mag_data), MAX_Y));
    w_peak_y = Y_BOTTOM - Y_W'(clamp_height(32'(w_peak), MAX_Y));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_peak_en    <= 1'b0;
      r_bin        <= '0;
      r_col        <= '0;
      r_x          <= '0;
      r_bar_y      <= Y_BOTTOM;
      r_peak_y     <= Y_BOTTOM;
      r_mag_addr   <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd.x0     <= '0;
      r_cmd.x1     <= '0;
      r_cmd.y0     <= LINE_Y_W'(Y_BOTTOM);
      r_cmd.y1     <= LINE_Y_W'(Y_BOTTOM);
      r_cmd.color  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_peak_en  <= i_peak_en;
            r_bin      <= '0;
            r_col      <= '0;
            r_x        <= '0;
            r_mag_addr <= '0;
            r_busy     <= 1'b1;
            r_state    <= StFetch;
          end
        end
        StFetch: begin
          r_state <= StWait;
        end
        StWait: begin
          r_bar_y     <= w_bar_y;
          r_peak_y    <= w_peak_y;
          r_cmd       <= make_cmd(r_x, Y_BOTTOM, w_bar_y);
          r_cmd_valid <= 1'b1;
          r_state     <= StBar;
        end
        StBar: begin
          if (w_fire) begin
            if (r_peak_en) begin
              r_cmd   <= make_cmd(r_x, r_peak_y, r_peak_y);
              r_state <= StPeak;
            end else begin
              r_cmd_valid <= 1'b0;
              if (w_last) begin
                r_frame_done <= 1'b1;
                r_state      <= StDone;
              end else begin
                r_state <= StNext;
              end
            end
          end
        end
        StPeak: begin
          if (w_fire) begin
            r_cmd_valid <= 1'b0;
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_state      <= StDone;
            end else begin
              r_state <= StNext;
            end
          end
        end
        StNext: begin
          // The final column never reaches here: it goes straight to done so
          // frame_done follows the last handshake by one cycle.
          r_x <= w_x_inc;
          if (!w_col_last) begin
            r_col       <= r_col + COL_W'(1);
            r_cmd       <= make_cmd(w_x_inc, Y_BOTTOM, r_bar_y);
            r_cmd_valid <= 1'b1;
            r_state     <= StBar;
          end else begin
            r_bin      <= r_bin + BIN_W'(1);
            r_col      <= '0;
            r_mag_addr <= r_bin + BIN_W'(1);
            r_state    <= StFetch;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mag_addr   = r_mag_addr;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_x0         = X_W'(r_cmd.x0);
  assign o_x1         = X_W'(r_cmd.x1);
  assign o_y0         = Y_W'(r_cmd.y0);
  assign o_y1         = Y_W'(r_cmd.y1);
  assign o_color      = r_cmd.color;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Bench for spectrum_bar_renderer: one default instance (BAR_W=1) and one with
// BAR_W=2, each fed by a synchronous magnitude RAM model. Expected command
// streams come from a plain per-bin/per-column enumeration with peak-hold state.
module tb_spectrum_bar_renderer;

  localparam int NB   = 512;
  localparam int MAXX = 640;
  localparam int YB   = 479;

  typedef struct {
    int x;
    int x1;
    int y0;
    int y1;
    int color;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, sel, peak_en, cmd_ready;
  logic start1, start2;
  assign start1 = start & ~sel;
  assign start2 = start & sel;

  logic [8:0] mag_addr1, mag_addr2, mag_data1, mag_data2;
  logic       valid1, valid2, color1, color2, busy1, busy2, done1, done2;
  logic [9:0] x01, x11, x02, x12;
  logic [8:0] y01, y11, y02, y12;

  int mem [NB];
  int pk1 [NB];
  int pk2 [NB];

  always @(posedge clk) begin
    mag_data1 <= 9'(mem[mag_addr1]);
    mag_data2 <= 9'(mem[mag_addr2]);
  end

  logic       o_valid, o_color, o_busy, o_done;
  logic [9:0] o_x0, o_x1;
  logic [8:0] o_y0, o_y1;
  assign o_valid = sel ? valid2 : valid1;
  assign o_color = sel ? color2 : color1;
  assign o_busy  = sel ? busy2  : busy1;
  assign o_done  = sel ? done2  : done1;
  assign o_x0    = sel ? x02 : x01;
  assign o_x1    = sel ? x12 : x11;
  assign o_y0    = sel ? y02 : y01;
  assign o_y1    = sel ? y12 : y11;

  spectrum_bar_renderer u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start1),
    .i_peak_en    (peak_en),
    .o_mag_addr   (mag_addr1),
    .i_mag_data   (mag_data1),
    .o_cmd_valid  (valid1),
    .i_cmd_ready  (cmd_ready),
    .o_x0         (x01),
    .o_x1         (x11),
    .o_y0         (y01),
    .o_y1         (y11),
    .o_color      (color1),
    .o_busy       (busy1),
    .o_frame_done (done1)
  );

  spectrum_bar_renderer #(.BAR_W(2)) u_dut2 (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start2),
    .i_peak_en    (peak_en),
    .o_mag_addr   (mag_addr2),
    .i_mag_data   (mag_data2),
    .o_cmd_valid  (valid2),
    .i_cmd_ready  (cmd_ready),
    .o_x0         (x02),
    .o_x1         (x12),
    .o_y0         (y02),
    .o_y1         (y12),
    .o_color      (color2),
    .o_busy       (busy2),
    .o_frame_done (done2)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t exp_q[$];
  cmd_t got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected command stream for one frame; also advances the peak-hold model.
  task automatic build_expected(input bit s, input bit pe);
    int   bw;
    int   m;
    int   p;
    cmd_t c;
    bw = s ? 2 : 1;
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      if (b * bw >= MAXX) break;
      m = mem[b];
      p = s ? pk2[b] : pk1[b];
      p = (p > 2) ? p - 2 : 0;
      if (m > p) p = m;
      if (s) pk2[b] = p; else pk1[b] = p;
      for (int col = 0; col < bw; col++) begin
        if (b * bw + col >= MAXX) break;
        c.x = b * bw + col; c.x1 = c.x; c.color = 1;
        c.y0 = YB; c.y1 = YB - min_i(m, YB);
        exp_q.push_back(c);
        if (pe) begin
          c.y0 = YB - min_i(p, YB); c.y1 = c.y0;
          exp_q.push_back(c);
        end
      end
    end
  endtask

  task automatic clear_peaks();
    for (int i = 0; i < NB; i++) begin
      pk1[i] = 0;
      pk2[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_peaks();
  endtask

  task automatic run_frame(input bit s, input bit pe, input int pct, input int abort_n,
                           input string tag);
    int         first_v, done_cnt, done_cyc, last_hs, stall_err, n_bad, bad_i;
    bit         stalled, finished;
    logic [9:0] h_x0, h_x1;
    logic [8:0] h_y0, h_y1;
    logic       h_c;
    cmd_t       c;
    build_expected(s, pe);
    got_q.delete();
    first_v = -1; done_cnt = 0; done_cyc = -1; last_hs = -1; stall_err = 0;
    stalled = 1'b0; finished = 1'b0;
    h_x0 = '0; h_x1 = '0; h_y0 = '0; h_y1 = '0; h_c = 1'b0;
    @(negedge clk);
    sel = s; peak_en = pe; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    peak_en = ~pe;  // must have been latched at start
    for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
      if (stalled && !(o_valid === 1'b1 && o_x0 === h_x0 && o_x1 === h_x1 &&
                       o_y0 === h_y0 && o_y1 === h_y1 && o_color === h_c))
        stall_err++;
      if (o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (done_cnt > 0 && o_busy === 1'b0) begin
        finished = 1'b1;
      end else begin
        start = (cyc == 40);  // re-start while busy must be ignored
        cmd_ready = ($urandom_range(99, 0) < pct);
        if (o_valid === 1'b1 && cmd_ready) begin
          c.x = o_x0; c.x1 = o_x1; c.y0 = o_y0; c.y1 = o_y1; c.color = o_color;
          got_q.push_back(c);
          last_hs = cyc;
          if (abort_n > 0 && got_q.size() == abort_n) begin
            start = 1'b0;
            return;
          end
        end
        stalled = (o_valid === 1'b1) && !cmd_ready;
        h_x0 = o_x0; h_x1 = o_x1; h_y0 = o_y0; h_y1 = o_y1; h_c = o_color;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({tag, " frame finished"}, finished, 1);
    check({tag, " first valid cycle"}, first_v, 2);
    check({tag, " frame_done pulses"}, done_cnt, 1);
    check({tag, " frame_done timing"}, done_cyc, last_hs + 1);
    check({tag, " stalled output changes"}, stall_err, 0);
    check({tag, " command count"}, got_q.size(), exp_q.size());
    n_bad = 0; bad_i = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].x != exp_q[i].x || got_q[i].x1 != exp_q[i].x || got_q[i].y0 != exp_q[i].y0 ||
          got_q[i].y1 != exp_q[i].y1 || got_q[i].color != 1) begin
        n_bad++;
        if (bad_i < 0) bad_i = i;
      end
    end
    if (bad_i >= 0)
      $display("  %s first differing cmd %0d: got x=%0d/%0d y=%0d..%0d c=%0d, want x=%0d y=%0d..%0d",
               tag, bad_i, got_q[bad_i].x, got_q[bad_i].x1, got_q[bad_i].y0, got_q[bad_i].y1,
               got_q[bad_i].color, exp_q[bad_i].x, exp_q[bad_i].y0, exp_q[bad_i].y1);
    check({tag, " commands differing"}, n_bad, 0);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; sel = 1'b0; peak_en = 1'b0; cmd_ready = 1'b0;
    clear_peaks();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset cmd_valid", valid1, 0);
    check("reset busy", busy1, 0);
    check("reset frame_done", done1, 0);
    check("reset color", color1, 0);
    check("reset x0", x01, 0);
    check("reset x1", x11, 0);
    check("reset y0", y01, YB);
    check("reset y1", y11, YB);
    check("reset mag_addr", mag_addr1, 0);
    check("reset dut2 cmd_valid", valid2, 0);

    // Ramp, no backpressure
    for (int i = 0; i < NB; i++) mem[i] = i;
    run_frame(1'b0, 1'b0, 100, 0, "ramp");
    check("ramp cmd3 x", got_q[3].x, 3);
    check("ramp cmd3 y1", got_q[3].y1, YB - 3);
    check("ramp cmd300 x", got_q[300].x, 300);
    check("ramp cmd300 y0", got_q[300].y0, YB);
    check("ramp cmd300 y1", got_q[300].y1, YB - 300);

    // Clamp and one-pixel bar
    mem[5] = 511; mem[6] = 0;
    run_frame(1'b0, 1'b0, 100, 0, "clamp");
    check("clamp cmd5 y1", got_q[5].y1, 0);
    check("clamp cmd6 y0", got_q[6].y0, YB);
    check("clamp cmd6 y1", got_q[6].y1, YB);

    // Backpressure on the ramp
    mem[5] = 5; mem[6] = 6;
    run_frame(1'b0, 1'b0, 30, 0, "backpressure");
    check("backpressure cmd100 y1", got_q[100].y1, YB - 100);

    // Two columns per bin, frame clipped at the display edge
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(511, 0);
    mem[3] = 200;
    run_frame(1'b1, 1'b0, 70, 0, "barw2");
    check("barw2 count", got_q.size(), MAXX);
    check("barw2 cmd6 x", got_q[6].x, 6);
    check("barw2 cmd7 x", got_q[7].x, 7);
    check("barw2 cmd6 y1", got_q[6].y1, YB - 200);
    check("barw2 cmd7 y1", got_q[7].y1, YB - 200);
    check("barw2 last x", got_q[MAXX - 1].x, MAXX - 1);

    // Peak hold and decay on bin 0
    do_reset();
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(511, 0);
    mem[0] = 100;
    run_frame(1'b0, 1'b1, 100, 0, "peak f1");
    check("peak f1 bar x", got_q[0].x, 0);
    check("peak f1 bar y1", got_q[0].y1, 379);
    check("peak f1 marker x", got_q[1].x, 0);
    check("peak f1 marker y0", got_q[1].y0, 379);
    check("peak f1 marker y1", got_q[1].y1, 379);
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(511, 0);
    mem[0] = 0;
    run_frame(1'b0, 1'b1, 100, 0, "peak f2");
    check("peak f2 bar y1", got_q[0].y1, YB);
    check("peak f2 marker y0", got_q[1].y0, 381);
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(511, 0);
    mem[0] = 0;
    run_frame(1'b0, 1'b1, 100, 0, "peak f3");
    check("peak f3 marker y0", got_q[1].y0, 383);

    // Random magnitudes, peak mode and backpressure
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(511, 0);
    run_frame(1'b0, 1'($urandom_range(1, 0)), 50, 0, "random");

    // Reset in the middle of a frame
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(511, 0);
    run_frame(1'b0, 1'b1, 60, 10, "abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_peaks();
    check("abort cmd_valid", valid1, 0);
    check("abort busy", busy1, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done1 === 1'b1) done_seen++;
      @(negedge clk);
    end
    check("abort no frame_done", done_seen, 0);

    // Fresh frame after reset: small magnitudes expose any stale peaks
    for (int i = 0; i < NB; i++) mem[i] = $urandom_range(40, 0);
    run_frame(1'b0, 1'b1, 100, 0, "after reset");
    check("after reset first x", got_q[0].x, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
